// File: rtl/rom_arbiter.sv
// Round-robin arbiter granting read bursts from two requesters onto one synchronous ROM.
// Latency: ack and the first rom_en one cycle after the grant edge; rdata/rvalid two cycles after each beat.
// Backpressure: none; a requester holds req until ack, and req is only sampled in IDLE.
module rom_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [2:0]        len0,
    input  logic [2:0]        len1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              last0,
    output logic              last1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_d;
    logic              ptr;
    logic              owner;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        beats_left;
    logic              first_beat;
    logic              drain_cnt;
    logic              grant_vld;
    logic              grant_id;
    logic              issue_last;

    // Beat pipeline: stage 1 tracks the beat whose ROM data arrives next cycle.
    logic              p1_vld;
    logic              p1_own;
    logic              p1_last;

    always_comb begin
        state_d    = state;
        grant_vld  = 1'b0;
        grant_id   = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_vld = 1'b1;
                    grant_id  = (req0 && req1) ? ptr : req1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (beats_left == 3'd0) begin
                    issue_last = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            cur_addr   <= '0;
            beats_left <= 3'd0;
            first_beat <= 1'b0;
            drain_cnt  <= 1'b0;
            p1_vld     <= 1'b0;
            p1_own     <= 1'b0;
            p1_last    <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            last0      <= 1'b0;
            last1      <= 1'b0;
            rdata      <= '0;
        end else begin
            first_beat <= grant_vld;
            if (grant_vld) begin
                owner      <= grant_id;
                ptr        <= ~grant_id;
                cur_addr   <= grant_id ? addr1 : addr0;
                beats_left <= grant_id ? len1 : len0;
            end else if (state == ISSUE) begin
                // Natural overflow gives the modulo-depth address wrap.
                cur_addr   <= cur_addr + 1'b1;
                beats_left <= beats_left - 3'd1;
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;

            p1_vld  <= (state == ISSUE);
            p1_own  <= owner;
            p1_last <= issue_last;

            rvalid0 <= p1_vld & ~p1_own;
            rvalid1 <= p1_vld &  p1_own;
            last0   <= p1_vld & p1_last & ~p1_own;
            last1   <= p1_vld & p1_last &  p1_own;
            if (p1_vld) begin
                rdata <= rom_data;
            end
        end
    end

    assign ack0     = first_beat & ~owner;
    assign ack1     = first_beat &  owner;
    assign rom_en   = (state == ISSUE);
    assign rom_addr = cur_addr;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a synchronous ROM model, mem[i] = 8'h10 + i.
module tb_rom_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0 = 1'b0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic [2:0]        len0 = 3'd0;
    logic [2:0]        len1 = 3'd0;
    logic              ack0, ack1, rvalid0, rvalid1, last0, last1, busy, rom_en;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;

    int n_vec = 0;
    int n_err = 0;

    rom_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .len0     (len0),
        .len1     (len1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .last0    (last0),
        .last1    (last1),
        .rdata    (rdata),
        .busy     (busy),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= 8'h10 + 8'(rom_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {24'd0, ack0, ack1, rvalid0, rvalid1, last0, last1, rom_en, busy}, 32'd0);
        check({tag, "_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] wrap_exp [4];
        int en_cnt, busy_cnt, nv, a0_cnt, a1_cnt, v_cnt, a0_cyc, a1_cyc, n_ack;
        int seq [3];
        wrap_exp = '{8'h16, 8'h17, 8'h10, 8'h11};

        // Reset state
        repeat (2) cyc();
        check_all_zero("reset");
        rst_n = 1'b1;
        cyc();

        // Single read
        req0 = 1'b1; addr0 = 3'd3; len0 = 3'd0;
        cyc();
        req0 = 1'b0;
        check("t1_ack0", ack0, 1);
        check("t1_rom_en", rom_en, 1);
        check("t1_rom_addr", 32'(rom_addr), 3);
        cyc();
        check("t1_ack0_c2", ack0, 0);
        check("t1_rom_en_c2", rom_en, 0);
        cyc();
        check("t1_rvalid0", rvalid0, 1);
        check("t1_last0", last0, 1);
        check("t1_rdata", 32'(rdata), 32'h13);
        cyc();
        check("t1_busy_c4", busy, 0);
        check("t1_rvalid0_c4", rvalid0, 0);

        // Wrap burst on requester 1
        req1 = 1'b1; addr1 = 3'd6; len1 = 3'd3;
        v_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 1) begin
                req1 = 1'b0;
                check("t2_ack1", ack1, 1);
            end
            check($sformatf("t2_rvalid1_c%0d", c), rvalid1, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                check($sformatf("t2_rdata_c%0d", c), 32'(rdata), 32'(wrap_exp[c-3]));
                check($sformatf("t2_last1_c%0d", c), last1, (c == 6));
            end
            v_cnt += int'(rvalid0);
        end
        check("t2_rvalid0_cnt", v_cnt, 0);
        check("t2_busy_c7", busy, 0);

        // Full 8-beat burst
        req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
        en_cnt = 0; busy_cnt = 0; nv = 0;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            if (c == 1) req0 = 1'b0;
            en_cnt   += int'(rom_en);
            busy_cnt += int'(busy);
            check($sformatf("t6_rom_en_c%0d", c), rom_en, (c <= 8));
            check($sformatf("t6_rvalid0_c%0d", c), rvalid0, (c >= 3 && c <= 10));
            if (rvalid0) begin
                check($sformatf("t6_rdata_b%0d", nv), 32'(rdata), 32'h10 + 32'(nv));
                check($sformatf("t6_last0_b%0d", nv), last0, (nv == 7));
                nv++;
            end
        end
        check("t6_en_cnt", en_cnt, 8);
        check("t6_busy_cnt", busy_cnt, 10);
        check("t6_beats", nv, 8);

        // Request 0 raised only while requester 1 is issuing
        req1 = 1'b1; addr1 = 3'd0; len1 = 3'd3;
        a0_cnt = 0; a1_cnt = 0; en_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            if (c == 1) begin req1 = 1'b0; req0 = 1'b1; end
            if (c == 5) req0 = 1'b0;
            a0_cnt += int'(ack0);
            a1_cnt += int'(ack1);
            en_cnt += int'(rom_en);
        end
        check("t4_ack0_cnt", a0_cnt, 0);
        check("t4_ack1_cnt", a1_cnt, 1);
        check("t4_en_cnt", en_cnt, 4);

        // Reset during beat 2 of an 8-beat burst (pointer now at requester 1)
        req0 = 1'b1; addr0 = 3'd0; len0 = 3'd7;
        cyc();
        req0 = 1'b0;
        cyc();
        check("t5_beat2_addr", 32'(rom_addr), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t5_rst");
        cyc();
        cyc();
        rst_n = 1'b1;
        v_cnt = 0; busy_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            v_cnt    += int'(rvalid0 | rvalid1);
            busy_cnt += int'(busy);
        end
        check("t5_no_rvalid", v_cnt, 0);
        check("t5_no_busy", busy_cnt, 0);

        // Contention from reset: pointer must start at requester 0
        req0 = 1'b1; req1 = 1'b1; addr0 = 3'd1; addr1 = 3'd2; len0 = 3'd0; len1 = 3'd0;
        a0_cyc = -1; a1_cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (ack0) begin a0_cyc = c; req0 = 1'b0; end
            if (ack1) begin a1_cyc = c; req1 = 1'b0; end
        end
        check("t3_ack0_cyc", a0_cyc, 1);
        check("t3_ack1_cyc", a1_cyc, 5);

        req0 = 1'b1; req1 = 1'b1;
        n_ack = 0;
        seq = '{-1, -1, -1};
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (ack0 || ack1) begin
                if (n_ack < 3) seq[n_ack] = ack1 ? 1 : 0;
                n_ack++;
                if (n_ack == 3) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        check("t3_n_ack", n_ack, 3);
        check("t3_grant0", seq[0], 0);
        check("t3_grant1", seq[1], 1);
        check("t3_grant2", seq[2], 0);

        // Lone request 1 served normally
        req1 = 1'b1; addr1 = 3'd5; len1 = 3'd0;
        cyc();
        req1 = 1'b0;
        check("t7_ack1", ack1, 1);
        check("t7_rom_addr", 32'(rom_addr), 5);
        cyc();
        cyc();
        check("t7_rvalid1", rvalid1, 1);
        check("t7_last1", last1, 1);
        check("t7_rdata", 32'(rdata), 32'h15);
        cyc();
        check("t7_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ROM data width.
REQ-002 SHALL have parameter ADDR_W, default 3, ROM address width (depth 2**ADDR_W).
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0, req1  input  1 each  read-burst request from requester 0 / 1.
REQ-006 addr0, addr1  input  ADDR_W each  burst start address.
REQ-007 len0, len1  input  3 each  burst length minus one (beats = len+1, 1..8).
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: request accepted.
REQ-009 rvalid0, rvalid1  output  1 each  rdata valid for requester 0 / 1.
REQ-010 last0, last1  output  1 each  final beat of burst, qualified by rvalid.
REQ-011 rdata  output  DATA_W  registered read data, shared by both requesters.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 rom_en  output  1  ROM read enable.
REQ-014 rom_addr  output  ADDR_W  ROM address.
REQ-015 rom_data  input  DATA_W  ROM output; valid the cycle after rom_en/rom_addr are presented.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-017 IDLE: when req0 or req1 is high at a clock edge, SHALL grant one requester, latch its addr/len, and enter ISSUE.
- Round-robin rule: when only one request is high, that requester is granted.
- When both are high, the requester pointed to by the priority pointer is granted.
REQ-018 Priority pointer SHALL reset to requester 0 and, after each grant, point to the non-granted requester.
REQ-019 ackN SHALL be high for exactly the first ISSUE cycle of requester N's burst.
REQ-020 ISSUE: SHALL drive rom_en=1 for exactly len+1 consecutive cycles.
- rom_addr equals the start address on the first beat and increments by 1 per beat, wrapping 2**ADDR_W-1 -> 0 (modulo 2**ADDR_W).
REQ-021 After the final ISSUE beat, SHALL enter DRAIN for exactly 2 cycles, then return to IDLE.
- rom_en=0 in DRAIN and IDLE.
REQ-022 For each beat issued in cycle t, SHALL register rom_data at the end of cycle t+1.
- rdata = ROM[beat address] in cycle t+2.
- rvalidN high in cycle t+2 for the owning requester only.
REQ-023 lastN SHALL be high with the rvalidN of the final beat only.
- A 1-beat burst has last high on its single beat.
REQ-024 Requests SHALL be sampled only in IDLE; req levels in ISSUE/DRAIN are ignored.
REQ-025 A requester SHALL hold req, addr and len stable until its ack.
- req still high in the next IDLE cycle starts a new burst.
REQ-026 Minimum gap between consecutive bursts SHALL be 1 IDLE cycle.
- Burst of B beats occupies B+2 non-IDLE cycles.
REQ-027 rvalid0 and rvalid1 SHALL never be high simultaneously.
REQ-028 When rvalid0 and rvalid1 are both low, rdata SHALL hold its last value.

Reset
REQ-029 rst_n low SHALL, asynchronously, force:
- state IDLE and priority pointer to requester 0;
- ack*, rvalid*, last*, rom_en, busy = 0;
- rom_addr = 0 and rdata = 0;
- all in-flight beats discarded.
REQ-030 After rst_n rises, SHALL arbitrate only at the first subsequent clock edge with a request high.
- No valid data from an aborted burst appears.

Verification
Bench ROM model: synchronous, mem[i] = 8'h10+i.
REQ-031 Single read: req0=1, addr0=3, len0=0 for one IDLE edge.
- ack0 in cycle 1; rom_en/rom_addr=3 in cycle 1.
- rvalid0=last0=1, rdata=8'h13 in cycle 3.
- busy low from cycle 4.
REQ-032 Wrap burst: req1, addr1=6, len1=3.
- rdata sequence 8'h16, 8'h17, 8'h10, 8'h11 on consecutive rvalid1 cycles.
- last1 only on 8'h11.
- rvalid0 stays 0.
REQ-033 Contention: req0 and req1 held high together from reset, len=0 each, released on ack.
- Grants in order 0, 1; ack1 exactly 4 cycles after ack0.
- Then with both held again: grants alternate 0, 1, 0, ...
REQ-034 Ignored request: req0 pulses high only during the ISSUE cycles of a requester-1 burst.
- No ack0 and no extra rom_en cycles.
REQ-035 Reset mid-burst: assert rst_n low during beat 2 of an 8-beat burst.
- All outputs 0 immediately; no rvalid after release.
- Next req1 is granted normally with priority pointer at requester 0.
REQ-036 Full burst: addr0=0, len0=7.
- 8 contiguous rom_en cycles; rdata 8'h10..8'h17 on 8 contiguous rvalid0 cycles.
- busy high for 10 cycles.
